// File: rtl/bus_sram_slave.sv
// bus_sram_slave: word-wide SRAM target behind a req/ack bus.
// Fixed latency with optional wait states and a decode-miss error.
module bus_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bus_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_byte_en,
  output logic        o_ack,
  output logic [31:0] o_rd_data,
  output logic        o_err
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    HOLD
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rd_q;
  logic        err_q;

  logic [31:0] mem [MEM_WORDS];

  logic [32:0]   off;
  logic          hit;
  logic [AW-1:0] idx;
  logic          fire;

  // Offset wraps past SPAN when addr is below the base.
  assign off  = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign hit  = off < SPAN;
  assign idx  = addr_q[AW+1:2];
  assign fire = (state == WAIT) && i_bus_en && (cnt == '0);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (i_bus_en) nxt = WAIT;
      WAIT: begin
        if (!i_bus_en)        nxt = IDLE;
        else if (cnt == '0)   nxt = ACK;
      end
      ACK:  nxt = HOLD;
      HOLD: if (!i_bus_en) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && i_bus_en) begin
        addr_q  <= i_addr;
        we_q    <= i_wr_en;
        wdata_q <= i_wr_data;
        be_q    <= i_byte_en;
        cnt     <= 4'(WAIT_STATES);
      end else if (state == WAIT && i_bus_en && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (fire) begin
        err_q <= !hit;
        if (!hit)       rd_q <= '0;
        else if (!we_q) rd_q <= mem[idx];
      end else begin
        err_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (fire && hit && we_q) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign o_ack     = (state == ACK);
  assign o_rd_data = rd_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// tb_bus_sram_slave: three instances (0/2/3 wait states) driven by
// directed and random traffic, checked against a word-array model.
module tb_bus_sram_slave;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          WORDS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_en [3];
  logic        wr_en  [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic [3:0]  be     [3];
  logic        ack    [3];
  logic [31:0] rdata  [3];
  logic        err    [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mm [3][WORDS];
  logic [31:0] last_rd [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    bus_sram_slave #(
      .BASE_ADDR  (BASE),
      .MEM_WORDS  (WORDS),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) dut (
      .i_clk    (clk),
      .i_rst    (rst_n),
      .i_bus_en (bus_en[g]),
      .i_wr_en  (wr_en[g]),
      .i_addr   (addr[g]),
      .i_wr_data(wdata[g]),
      .i_byte_en(be[g]),
      .o_ack    (ack[g]),
      .o_rd_data(rdata[g]),
      .o_err    (err[g])
    );
  end

  function automatic int ws(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  function automatic bit hit(input logic [31:0] a);
    return (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'(4 * WORDS));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (b[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input int d, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] b,
                     input int extra, output logic [31:0] rd,
                     output logic er);
    int n;
    bit got;
    @(negedge clk);
    bus_en[d] = 1'b1;
    wr_en[d]  = we;
    addr[d]   = a;
    wdata[d]  = wd;
    be[d]     = b;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (ack[d]) got = 1;
      else begin
        wr_en[d] = 1'($urandom);
        addr[d]  = $urandom;
        wdata[d] = $urandom;
        be[d]    = 4'($urandom);
      end
    end
    chk($sformatf("latency%0d", d), 32'(n), 32'(2 + ws(d)));
    rd = rdata[d];
    er = err[d];
    for (int i = 0; i <= extra; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("single_ack%0d", d), {31'b0, ack[d]}, 32'd0);
    end
    bus_en[d] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic mtxn(input int d, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b,
                      input int extra, output logic [31:0] rd);
    logic er;
    logic [31:0] exp_rd;
    bit h;
    int i;
    h = hit(a);
    i = h ? widx(a) : 0;
    if (!h)      exp_rd = '0;
    else if (we) exp_rd = last_rd[d];
    else         exp_rd = mm[d][i];
    txn(d, we, a, wd, b, extra, rd, er);
    chk($sformatf("err%0d", d), {31'b0, er}, {31'b0, !h});
    chk($sformatf("rdata%0d", d), rd, exp_rd);
    last_rd[d] = exp_rd;
    if (h && we) mm[d][i] = merge(mm[d][i], wd, b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    bit we;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      bus_en[d] = 0; wr_en[d] = 0; addr[d] = 0;
      wdata[d] = 0; be[d] = 0; last_rd[d] = 0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ack", {31'b0, ack[d]}, 32'd0);
      chk("rst_err", {31'b0, err[d]}, 32'd0);
      chk("rst_rd", rdata[d], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 3; d++)
      for (int i = 0; i < WORDS; i++)
        mtxn(d, 1, BASE + 32'(4 * i), $urandom, 4'hF, 0, r);

    mtxn(0, 1, BASE + 8, 32'hDEADBEEF, 4'hF, 0, r);
    mtxn(0, 0, BASE + 8, 0, 4'h0, 0, r);
    chk("rd_full", r, 32'hDEADBEEF);
    mtxn(0, 1, BASE + 12, 32'h11223344, 4'hF, 0, r);
    mtxn(0, 1, BASE + 12, 32'h0000AB00, 4'b0010, 0, r);
    mtxn(0, 0, BASE + 12, 0, 4'h0, 0, r);
    chk("rd_partial", r, 32'h1122AB44);
    mtxn(0, 1, BASE + 12, 32'hFFFFFFFF, 4'b0000, 0, r);
    mtxn(0, 0, BASE + 12, 0, 4'hF, 1, r);
    chk("rd_be0", r, 32'h1122AB44);
    mtxn(0, 0, BASE + 64, 0, 4'hF, 0, r);
    chk("rd_miss_hi", r, 32'd0);
    mtxn(0, 0, BASE - 4, 0, 4'hF, 0, r);
    mtxn(0, 0, BASE + 8, 0, 4'hF, 0, r);
    chk("rd_after_miss", r, 32'hDEADBEEF);

    mtxn(2, 1, BASE + 20, 32'h0BADF00D, 4'hF, 0, r);
    mtxn(2, 0, BASE + 20, 0, 4'h0, 1, r);
    chk("rd_ws3", r, 32'h0BADF00D);

    @(negedge clk);
    bus_en[2] = 1; wr_en[2] = 1; addr[2] = BASE + 20;
    wdata[2] = 32'h55AA55AA; be[2] = 4'hF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", {31'b0, ack[2]}, 32'd0);
    chk("mid_rst_rd", rdata[2], 32'd0);
    chk("mid_rst_err", {31'b0, err[2]}, 32'd0);
    bus_en[2] = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("mid_rst_noack", {31'b0, ack[2]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++) last_rd[d] = '0;
    mtxn(2, 0, BASE + 20, 0, 4'hF, 0, r);
    chk("rd_after_rst", r, 32'h0BADF00D);

    mtxn(1, 1, BASE + 24, 32'h13579BDF, 4'hF, 0, r);
    mtxn(1, 0, BASE + 24, 0, 4'hF, 0, r);
    @(negedge clk);
    bus_en[1] = 1; wr_en[1] = 1; addr[1] = BASE + 24;
    wdata[1] = 32'hFFFF0000; be[1] = 4'hF;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("drop_noack0", {31'b0, ack[1]}, 32'd0);
    @(negedge clk);
    bus_en[1] = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("drop_noack", {31'b0, ack[1]}, 32'd0);
      chk("drop_rd_hold", rdata[1], last_rd[1]);
    end
    mtxn(1, 0, BASE + 24, 0, 4'hF, 0, r);
    chk("rd_after_drop", r, 32'h13579BDF);

    for (int d = 0; d < 3; d++) begin
      for (int t = 0; t < 40; t++) begin
        we = 1'($urandom);
        a = BASE + 32'(4 * $urandom_range(WORDS - 1)) + 32'($urandom_range(3));
        if (!we && $urandom_range(4) == 0)
          a = $urandom_range(1) ? BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(50))
                                : BASE - 32'(4 * $urandom_range(1, 50));
        mtxn(d, we, a, $urandom, 4'($urandom), $urandom_range(2), r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
